// File: rtl/qr_pkg.sv
// Shared constants and types for the QR finder-pattern pipeline.
package qr_pkg;

  localparam int unsigned FRAME_HEIGHT = 480;
  localparam int unsigned FRAME_WIDTH  = 480;
  localparam int unsigned ROW_W        = $clog2(FRAME_HEIGHT);

  typedef struct packed {
    logic [ROW_W-1:0] start_row;
    logic [ROW_W-1:0] end_row;
    logic [ROW_W-1:0] center_row;
  } cluster_rec_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFlush,
    StDone
  } clus_state_e;

endpackage

// File: rtl/finder_row_clusterer_if.sv
// Flag-vector input and cluster-record output bundle of the row clusterer.
interface finder_row_clusterer_if
  import qr_pkg::*;
#(
  parameter int unsigned HEIGHT = FRAME_HEIGHT
);
  logic [HEIGHT-1:0] finder_encodings;
  logic              encodings_valid;
  logic              busy;
  logic              cluster_valid;
  logic [ROW_W-1:0]  cluster_start;
  logic [ROW_W-1:0]  cluster_end;
  logic [ROW_W-1:0]  cluster_center;
  logic [1:0]        cluster_id;
  logic [1:0]        cluster_count;
  logic              overflow;
  logic              done;

  modport master (
    output finder_encodings, encodings_valid,
    input  busy, cluster_valid, cluster_start, cluster_end, cluster_center,
    input  cluster_id, cluster_count, overflow, done
  );

  modport slave (
    input  finder_encodings, encodings_valid,
    output busy, cluster_valid, cluster_start, cluster_end, cluster_center,
    output cluster_id, cluster_count, overflow, done
  );
endinterface

// File: rtl/finder_row_clusterer_run_tracker.sv
// Groups serially presented row flags into runs, tolerating short gaps of zeros.
module finder_row_clusterer_run_tracker
  import qr_pkg::*;
#(
  parameter int unsigned MAX_GAP = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             en,
  input  logic             row_bit,
  input  logic [ROW_W-1:0] index,
  input  logic             last,
  output logic             close_pulse,
  output logic [ROW_W-1:0] start_row,
  output logic [ROW_W-1:0] end_row
);
  localparam int unsigned GapW = $clog2(MAX_GAP + 2) + 1;

  logic             run_q, run_d;
  logic [ROW_W-1:0] start_q, start_d, end_q, end_d;
  logic [GapW-1:0]  gap_q, gap_d;

  always_comb begin
    run_d       = run_q;
    start_d     = start_q;
    end_d       = end_q;
    gap_d       = gap_q;
    close_pulse = 1'b0;
    if (en) begin
      if (row_bit) begin
        if (!run_q) start_d = index;
        run_d = 1'b1;
        end_d = index;
        gap_d = '0;
      end else if (run_q) begin
        gap_d = gap_q + 1'b1;
        if (gap_d > GapW'(MAX_GAP)) close_pulse = 1'b1;
      end
      // The final row closes whatever is still open, after that row is applied.
      if (last && run_d) close_pulse = 1'b1;
      if (close_pulse) begin
        run_d = 1'b0;
        gap_d = '0;
      end
    end
  end

  assign start_row = start_d;
  assign end_row   = end_d;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      run_q   <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      gap_q   <= '0;
    end else begin
      run_q   <= run_d;
      start_q <= start_d;
      end_q   <= end_d;
      gap_q   <= gap_d;
    end
  end
endmodule

// File: rtl/finder_row_clusterer.sv
// Scans a per-row finder flag vector and reports up to MAX_CLUSTERS vertical clusters.
module finder_row_clusterer
  import qr_pkg::*;
#(
  parameter int unsigned HEIGHT       = FRAME_HEIGHT,
  parameter int unsigned MIN_RUN      = 3,
  parameter int unsigned MAX_GAP      = 2,
  parameter int unsigned MAX_CLUSTERS = 3
) (
  input logic                   clk_in,
  input logic                   rst_in,
  finder_row_clusterer_if.slave bus
);
  clus_state_e       state_q, state_d;
  logic [HEIGHT-1:0] vec_q;
  logic [ROW_W-1:0]  idx_q;
  cluster_rec_t      rec_q;
  logic [1:0]        id_q, count_q;
  logic              ovf_q, valid_q;

  logic             accept, scanning, last_row, close_pulse, qualifies;
  logic [ROW_W-1:0] run_start, run_end;
  logic [ROW_W:0]   run_len, center_sum;

  assign accept   = (state_q == StIdle) && bus.encodings_valid;
  assign scanning = (state_q == StScan);
  assign last_row = (idx_q == ROW_W'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.encodings_valid) state_d = StScan;
      StScan:  if (last_row) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  finder_row_clusterer_run_tracker #(
    .MAX_GAP (MAX_GAP)
  ) u_run_tracker (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear       (accept),
    .en          (scanning),
    .row_bit     (vec_q[idx_q]),
    .index       (idx_q),
    .last        (last_row),
    .close_pulse (close_pulse),
    .start_row   (run_start),
    .end_row     (run_end)
  );

  assign run_len    = {1'b0, run_end} - {1'b0, run_start} + (ROW_W + 1)'(1);
  assign center_sum = {1'b0, run_start} + {1'b0, run_end};
  assign qualifies  = close_pulse && (run_len >= (ROW_W + 1)'(MIN_RUN));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vec_q   <= '0;
      idx_q   <= '0;
      rec_q   <= '0;
      id_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        vec_q   <= bus.finder_encodings;
        idx_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
      if (scanning) begin
        if (!last_row) idx_q <= idx_q + 1'b1;
        if (qualifies) begin
          if (count_q < 2'(MAX_CLUSTERS)) begin
            rec_q   <= '{start_row: run_start, end_row: run_end,
                         center_row: center_sum[ROW_W:1]};
            id_q    <= count_q;
            count_q <= count_q + 1'b1;
            valid_q <= 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy           = scanning || (state_q == StFlush);
  assign bus.done           = (state_q == StDone);
  assign bus.cluster_valid  = valid_q;
  assign bus.cluster_start  = rec_q.start_row;
  assign bus.cluster_end    = rec_q.end_row;
  assign bus.cluster_center = rec_q.center_row;
  assign bus.cluster_id     = id_q;
  assign bus.cluster_count  = count_q;
  assign bus.overflow       = ovf_q;
endmodule

// File: tb/tb_finder_row_clusterer.sv
// Directed table plus randomized frames checked against a set-bit grouping model.
module tb_finder_row_clusterer;
  import qr_pkg::*;

  localparam int H       = 480;
  localparam int MIN_RUN = 3;
  localparam int MAX_GAP = 2;
  localparam int MAXC    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  finder_row_clusterer_if #(.HEIGHT(H)) bus ();

  finder_row_clusterer #(
    .HEIGHT       (H),
    .MIN_RUN      (MIN_RUN),
    .MAX_GAP      (MAX_GAP),
    .MAX_CLUSTERS (MAXC)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Observed frame results
  int got_n, done_cyc, got_cnt, got_ovf, busy_bad, done_after;
  int got_s[8], got_e[8], got_c[8], got_id[8], got_cyc[8];
  // Expected frame results
  int exp_n, exp_cnt, exp_ovf;
  int exp_s[4], exp_e[4], exp_c[4], exp_cyc[4];

  typedef struct {
    int lo[4];
    int hi[4];
    int repulse;
    int n;
    int es[3];
    int ee[3];
    int ec[3];
    int ecyc[3];
    int cnt;
    int ovf;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [H-1:0] build(input int lo[4], input int hi[4]);
    logic [H-1:0] v = '0;
    for (int r = 0; r < 4; r++)
      if (lo[r] >= 0)
        for (int b = lo[r]; b <= hi[r]; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic close_run(input int s, input int e);
    int c;
    if (e - s + 1 >= MIN_RUN) begin
      if (exp_n < MAXC) begin
        c = e + MAX_GAP + 1;
        if (c > H - 1) c = H - 1;
        exp_s[exp_n]   = s;
        exp_e[exp_n]   = e;
        exp_c[exp_n]   = (s + e) / 2;
        exp_cyc[exp_n] = c + 2;
        exp_n++;
      end else begin
        exp_ovf = 1;
      end
    end
  endtask

  // Clusters are maximal groups of set rows separated by at most MAX_GAP zero rows.
  task automatic model(input logic [H-1:0] v);
    int cs, ce;
    bit open;
    exp_n = 0; exp_ovf = 0; open = 0; cs = 0; ce = 0;
    for (int p = 0; p < H; p++) begin
      if (v[p]) begin
        if (open && (p - ce - 1 <= MAX_GAP)) ce = p;
        else begin
          if (open) close_run(cs, ce);
          open = 1; cs = p; ce = p;
        end
      end
    end
    if (open) close_run(cs, ce);
    exp_cnt = exp_n;
  endtask

  task automatic run_frame(input logic [H-1:0] v, input int repulse);
    @(negedge clk);
    bus.finder_encodings = v;
    bus.encodings_valid  = 1'b1;
    @(posedge clk);
    got_n = 0; done_cyc = -1; busy_bad = 0; got_cnt = -1; got_ovf = -1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      bus.encodings_valid  = (i == repulse);
      bus.finder_encodings = (i == repulse) ? ~v : '0;
      if (bus.cluster_valid) begin
        if (got_n < 8) begin
          got_s[got_n]   = int'(bus.cluster_start);
          got_e[got_n]   = int'(bus.cluster_end);
          got_c[got_n]   = int'(bus.cluster_center);
          got_id[got_n]  = int'(bus.cluster_id);
          got_cyc[got_n] = i;
        end
        got_n++;
      end
      if (bus.done) begin
        done_cyc = i;
        got_cnt  = int'(bus.cluster_count);
        got_ovf  = int'(bus.overflow);
        if (bus.busy) busy_bad++;
        break;
      end else if (!bus.busy) begin
        busy_bad++;
      end
    end
    @(negedge clk);
    done_after = int'(bus.done);
    bus.encodings_valid = 1'b0;
  endtask

  task automatic compare(input string tag);
    check({tag, ".done_cycle"}, done_cyc, H + 2);
    check({tag, ".n_pulses"}, got_n, exp_n);
    check({tag, ".count"}, got_cnt, exp_cnt);
    check({tag, ".overflow"}, got_ovf, exp_ovf);
    check({tag, ".busy_bad"}, busy_bad, 0);
    check({tag, ".done_width"}, done_after, 0);
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      check($sformatf("%s.c%0d.start", tag, i), got_s[i], exp_s[i]);
      check($sformatf("%s.c%0d.end", tag, i), got_e[i], exp_e[i]);
      check($sformatf("%s.c%0d.center", tag, i), got_c[i], exp_c[i]);
      check($sformatf("%s.c%0d.id", tag, i), got_id[i], i);
      check($sformatf("%s.c%0d.cycle", tag, i), got_cyc[i], exp_cyc[i]);
    end
  endtask

  task automatic load_expected(input int t);
    exp_n = tbl[t].n; exp_cnt = tbl[t].cnt; exp_ovf = tbl[t].ovf;
    for (int i = 0; i < 3; i++) begin
      exp_s[i] = tbl[t].es[i]; exp_e[i] = tbl[t].ee[i];
      exp_c[i] = tbl[t].ec[i]; exp_cyc[i] = tbl[t].ecyc[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".valid"}, bus.cluster_valid, 0);
    check({tag, ".done"}, bus.done, 0);
    check({tag, ".count"}, bus.cluster_count, 0);
    check({tag, ".overflow"}, bus.overflow, 0);
    check({tag, ".start"}, bus.cluster_start, 0);
    check({tag, ".end"}, bus.cluster_end, 0);
    check({tag, ".center"}, bus.cluster_center, 0);
    check({tag, ".id"}, bus.cluster_id, 0);
  endtask

  initial begin
    logic [H-1:0] v;
    int pulses, dones, nr, lo, len;

    tbl[0] = '{lo: '{-1, -1, -1, -1}, hi: '{-1, -1, -1, -1}, repulse: 0, n: 0,
               es: '{0, 0, 0}, ee: '{0, 0, 0}, ec: '{0, 0, 0}, ecyc: '{0, 0, 0},
               cnt: 0, ovf: 0};
    tbl[1] = '{lo: '{100, -1, -1, -1}, hi: '{120, -1, -1, -1}, repulse: 0, n: 1,
               es: '{100, 0, 0}, ee: '{120, 0, 0}, ec: '{110, 0, 0}, ecyc: '{125, 0, 0},
               cnt: 1, ovf: 0};
    tbl[2] = '{lo: '{10, 17, 30, 37}, hi: '{14, 20, 33, 40}, repulse: 0, n: 3,
               es: '{10, 30, 37}, ee: '{20, 33, 40}, ec: '{15, 31, 38}, ecyc: '{25, 38, 45},
               cnt: 3, ovf: 0};
    tbl[3] = '{lo: '{200, 470, -1, -1}, hi: '{201, 479, -1, -1}, repulse: 0, n: 1,
               es: '{470, 0, 0}, ee: '{479, 0, 0}, ec: '{474, 0, 0}, ecyc: '{481, 0, 0},
               cnt: 1, ovf: 0};
    tbl[4] = '{lo: '{5, 50, 150, 300}, hi: '{9, 59, 159, 309}, repulse: 0, n: 3,
               es: '{5, 50, 150}, ee: '{9, 59, 159}, ec: '{7, 54, 154}, ecyc: '{14, 64, 164},
               cnt: 3, ovf: 1};
    tbl[5] = tbl[1];
    tbl[5].repulse = 200;

    bus.finder_encodings = '0;
    bus.encodings_valid  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      v = build(tbl[t].lo, tbl[t].hi);
      run_frame(v, tbl[t].repulse);
      load_expected(t);
      compare($sformatf("table%0d", t));
    end

    // Abort mid-scan: reset at cycle 250, after the first cluster has been counted.
    v = build(tbl[1].lo, tbl[1].hi);
    @(negedge clk);
    bus.finder_encodings = v;
    bus.encodings_valid  = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      bus.encodings_valid = 1'b0;
    end
    check("abort.pre_count", bus.cluster_count, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    pulses = 0; dones = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.cluster_valid) pulses++;
      if (bus.done) dones++;
    end
    check("abort.pulses_after", pulses, 0);
    check("abort.dones_after", dones, 0);
    run_frame(v, 0);
    load_expected(1);
    compare("after_abort");

    for (int f = 0; f < 25; f++) begin
      v = '0;
      nr = $urandom_range(0, 6);
      for (int r = 0; r < nr; r++) begin
        lo  = $urandom_range(0, H - 1);
        len = $urandom_range(1, 12);
        for (int b = lo; b < lo + len && b < H; b++) v[b] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 6);
        lo  = H - len - $urandom_range(0, 3);
        for (int b = lo; b < lo + len; b++) v[b] = 1'b1;
      end
      for (int k = 0; k < 4; k++) v[$urandom_range(0, H - 1)] = 1'b0;
      model(v);
      run_frame(v, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 481)) : 0);
      compare($sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
